// File: rtl/regfile_port_arbiter_if.sv
// Requester-side handshake bundle for regfile_port_arbiter: two request/response ports.
// master = requesters, slave = arbiter.
interface regfile_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_rvalid;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_rvalid;
    logic [DATA_WIDTH-1:0] req1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for the single register-file port: IDLE -> ACCESS -> RESP per transaction.
// RFARB_FIXED_PRIO_EN selects fixed priority (req0 wins); default is round-robin.
module regfile_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_arbiter_if.slave bus,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
`ifndef RFARB_FIXED_PRIO_EN
    logic                  last_grant;
`endif

    // Grants are suppressed while rst is high so no request is consumed by a cycle that gets reset away.
    always_comb begin
        grant0 = '0;
        grant1 = '0;
        if (state == IDLE && !rst) begin
`ifdef RFARB_FIXED_PRIO_EN
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid & ~bus.req0_valid;
`else
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
`endif
        end
        accept = grant0 | grant1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            lat_we    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifndef RFARB_FIXED_PRIO_EN
            last_grant <= '1;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                owner     <= grant1;
                lat_we    <= grant1 ? bus.req1_we    : bus.req0_we;
                lat_addr  <= grant1 ? bus.req1_addr  : bus.req0_addr;
                lat_wdata <= grant1 ? bus.req1_wdata : bus.req0_wdata;
`ifndef RFARB_FIXED_PRIO_EN
                last_grant <= grant1;
`endif
            end
        end
    end

    // rf_wen stays live during a reset in ACCESS; the response is dropped if reset lands in RESP.
    always_comb begin
        bus.req0_ready  = grant0;
        bus.req1_ready  = grant1;
        rf_wen          = '0;
        rf_waddr        = '0;
        rf_wdata        = '0;
        bus.req0_rvalid = '0;
        bus.req0_rdata  = '0;
        bus.req1_rvalid = '0;
        bus.req1_rdata  = '0;
        if (state == ACCESS) begin
            rf_wen   = lat_we;
            rf_waddr = lat_addr;
            rf_wdata = lat_wdata;
        end
        if (state == RESP && !rst) begin
            if (owner) begin
                bus.req1_rvalid = '1;
                bus.req1_rdata  = rf_rdata;
            end else begin
                bus.req0_rvalid = '1;
                bus.req0_rdata  = rf_rdata;
            end
        end
    end
endmodule
